// File: rtl/alu_pkg.sv
// alu_pkg: constants shared by the control unit and the ALU.
//   - opcode values 0x0..0xF (ALU ops occupy 0x0..0xA)
//   - FSM state encoding of the control unit
//   - bit positions of {Z,N,C,V} inside the 4-bit flag word
package alu_pkg;

    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_SUB    = 4'h1;
    localparam logic [3:0] OP_AND    = 4'h2;
    localparam logic [3:0] OP_OR     = 4'h3;
    localparam logic [3:0] OP_XOR    = 4'h4;
    localparam logic [3:0] OP_NAND   = 4'h5;
    localparam logic [3:0] OP_NOR    = 4'h6;
    localparam logic [3:0] OP_XNOR   = 4'h7;
    localparam logic [3:0] OP_NOT    = 4'h8;
    localparam logic [3:0] OP_LSHIFT = 4'h9;
    localparam logic [3:0] OP_RSHIFT = 4'hA;
    localparam logic [3:0] OP_LDI    = 4'hB;
    localparam logic [3:0] OP_BRZ    = 4'hC;
    localparam logic [3:0] OP_JMP    = 4'hD;
    localparam logic [3:0] OP_OUT    = 4'hE;
    localparam logic [3:0] OP_HALT   = 4'hF;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_WRITEBACK = 3'd3,
        ST_HALT      = 3'd4
    } state_e;

    // ALU ops are the contiguous block starting at 0x0.
    function automatic logic is_alu_op(input logic [3:0] op);
        return op <= OP_RSHIFT;
    endfunction

endpackage

// File: rtl/alu_control_unit_if.sv
// alu_control_unit_if: bundle between the control unit and the ALU.
//   instr / reg_a / reg_b : opcode and operands from the control unit
//   result / flags        : combinational ALU result and {Z,N,C,V}
// master = control unit side, slave = ALU side.
interface alu_control_unit_if;
    logic [3:0] instr;
    logic [3:0] reg_a;
    logic [3:0] reg_b;
    logic [3:0] result;
    logic [3:0] flags;

    modport master (output instr, output reg_a, output reg_b,
                    input  result, input flags);
    modport slave  (input  instr, input  reg_a, input  reg_b,
                    output result, output flags);
endinterface

// File: rtl/reg_file_4x4.sv
// reg_file_4x4: four 4-bit registers.
//   clk, rst_n        : clock, asynchronous active-low reset (clears all)
//   we/waddr/wdata    : single synchronous write port
//   raddr_a/raddr_b   : two combinational read ports -> rdata_a/rdata_b
module reg_file_4x4 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [1:0] waddr,
    input  logic [3:0] wdata,
    input  logic [1:0] raddr_a,
    input  logic [1:0] raddr_b,
    output logic [3:0] rdata_a,
    output logic [3:0] rdata_b
);
    logic [3:0][3:0] regs_q, regs_d;

    always_comb begin
        regs_d = regs_q;
        if (we) regs_d[waddr] = wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) regs_q <= '0;
        else        regs_q <= regs_d;
    end

    // Reads see the stored value, so a same-cycle write is not forwarded.
    assign rdata_a = regs_q[raddr_a];
    assign rdata_b = regs_q[raddr_b];
endmodule

// File: rtl/alu_control_unit.sv
// alu_control_unit: 4-cycle multicycle controller driving an external ALU.
//   iClk, iRst_n      : clock, asynchronous active-low reset
//   iEnable           : 1 = advance, 0 = freeze everything
//   ovDireccion       : program memory address (= PC)
//   ivDatoPrograma    : program word, valid one cycle after the address
//   ovInstruccion, ovRegistroA/B : opcode and operands to the ALU
//   ivResultado, ivFlags         : ALU result and {Z,N,C,V}
//   ovFlagsReg, ovPuerto, oHalt  : flag register, output port, halted
// Each instruction walks FETCH -> DECODE -> EXECUTE -> WRITEBACK; all
// architectural state changes on the WRITEBACK edge.
module alu_control_unit
    import alu_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic            iClk,
    input  logic            iRst_n,
    input  logic            iEnable,
    output logic [PC_W-1:0] ovDireccion,
    input  logic [15:0]     ivDatoPrograma,
    output logic [3:0]      ovInstruccion,
    output logic [3:0]      ovRegistroA,
    output logic [3:0]      ovRegistroB,
    input  logic [3:0]      ivResultado,
    input  logic [3:0]      ivFlags,
    output logic [3:0]      ovFlagsReg,
    output logic [3:0]      ovPuerto,
    output logic            oHalt
);
    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;
    logic [3:0]      flags_q, flags_d, port_q, port_d;
    logic [3:0]      instr_q, instr_d, opa_q, opa_d, opb_q, opb_d;
    logic            rf_we;
    logic [3:0]      rf_wdata, rd_a, rd_b;
    logic [1:0]      rf_raddr_a;
    logic [3:0]      ir_op;

    assign ir_op = ir_q[15:12];

    // Port A reads the incoming word's ra while decoding (operand capture)
    // and the latched ra afterwards (OUT in WRITEBACK).
    assign rf_raddr_a = (state_q == ST_DECODE) ? ivDatoPrograma[9:8] : ir_q[9:8];

    reg_file_4x4 u_reg_file (
        .clk     (iClk),
        .rst_n   (iRst_n),
        .we      (rf_we),
        .waddr   (ir_q[11:10]),
        .wdata   (rf_wdata),
        .raddr_a (rf_raddr_a),
        .raddr_b (ivDatoPrograma[7:6]),
        .rdata_a (rd_a),
        .rdata_b (rd_b)
    );

    // ---- FSM: state register ----
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) state_q <= ST_FETCH;
        else         state_q <= state_d;
    end

    // ---- FSM: next state ----
    always_comb begin
        state_d = state_q;
        if (iEnable) begin
            case (state_q)
                ST_FETCH:     state_d = ST_DECODE;
                ST_DECODE:    state_d = ST_EXECUTE;
                ST_EXECUTE:   state_d = ST_WRITEBACK;
                ST_WRITEBACK: state_d = (ir_op == OP_HALT) ? ST_HALT : ST_FETCH;
                ST_HALT:      state_d = ST_HALT;
                default:      state_d = ST_FETCH;
            endcase
        end
    end

    // ---- FSM: outputs ----
    always_comb begin
        oHalt = (state_q == ST_HALT);
    end

    // ---- datapath next values ----
    always_comb begin
        pc_d     = pc_q;
        ir_d     = ir_q;
        flags_d  = flags_q;
        port_d   = port_q;
        instr_d  = instr_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        rf_we    = 1'b0;
        rf_wdata = ivResultado;
        if (iEnable) begin
            if (state_q == ST_DECODE) begin
                // Operands are registered here so they appear throughout
                // EXECUTE and hold afterwards; no write can intervene before
                // WRITEBACK, so rd==ra/rb sees the old value.
                ir_d    = ivDatoPrograma;
                instr_d = ivDatoPrograma[15:12];
                opa_d   = rd_a;
                opb_d   = rd_b;
            end
            if (state_q == ST_WRITEBACK) begin
                pc_d = pc_q + PC_W'(1);
                if (is_alu_op(ir_op)) begin
                    rf_we   = 1'b1;
                    flags_d = ivFlags;
                end
                case (ir_op)
                    OP_LDI: begin
                        rf_we    = 1'b1;
                        rf_wdata = ir_q[3:0];
                    end
                    OP_BRZ:  if (flags_q[FLAG_Z]) pc_d = PC_W'(ir_q[7:0]);
                    OP_JMP:  pc_d = PC_W'(ir_q[7:0]);
                    OP_OUT:  port_d = rd_a;
                    OP_HALT: pc_d = pc_q;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            pc_q    <= '0;
            ir_q    <= '0;
            flags_q <= '0;
            port_q  <= '0;
            instr_q <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            flags_q <= flags_d;
            port_q  <= port_d;
            instr_q <= instr_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
        end
    end

    assign ovDireccion   = pc_q;
    assign ovInstruccion = instr_q;
    assign ovRegistroA   = opa_q;
    assign ovRegistroB   = opb_q;
    assign ovFlagsReg    = flags_q;
    assign ovPuerto      = port_q;
endmodule
